load_arbiter: RTL and testbench

LOAD_ARBITER -- requirements
Module: load_arbiter

---
 rtl/load_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 35 +++
 rtl/load_arbiter.sv | 130 +++++++++++++
 tb/tb_load_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_arb_pkg.sv
// Shared definitions for the load arbiter: FSM state encoding, default
// sizes and a helper that sizes requester-id fields.
package load_arb_pkg;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Width of a requester index; never less than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans req starting at index ptr,
// wrapping past N-1, and returns the first set requester.
module rr_pick
    import load_arb_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] id
);

    // Walk from farthest to nearest so the nearest requester at or after ptr
    // is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int            s;
            logic [IW-1:0] idx;
            s = int'(ptr) + k;
            if (s >= N) begin
                s = s - N;
            end
            idx = IW'(s);
            if (req[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/load_arbiter.sv
// Arbitrates N requesters onto one shared parallel-load register.
// Each grant runs IDLE -> LOAD (one-cycle load strobe) -> ACK (one-cycle ack
// pulse) -> IDLE, so peak throughput is one load every three cycles.
// Build option: define LOAD_ARB_LOCK_EN to let a requester holding lock[id]
// during its ACK cycle keep the round-robin pointer, winning again next time.
module load_arbiter
    import load_arb_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data,
    input  logic [N-1:0]   lock,
    output logic           load,
    output logic [W-1:0]   d,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic           busy
);

    localparam int IW = id_width(N);

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  id_q, id_d;
    logic [W-1:0]   data_q, data_d;

    logic           pick_valid;
    logic [IW-1:0]  pick_id;
    logic [IW-1:0]  ptr_adv;
    logic [W-1:0]   slice [N];

    // Split the flat data bus into per-requester slices.
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign slice[gi] = data[gi*W +: W];
    end

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    // Pointer moves to the requester just after the one being acknowledged.
    assign ptr_adv = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;

`ifndef LOAD_ARB_LOCK_EN
    // Lock has no effect in this build; fold it so it is still consumed.
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // State register; reset aborts any grant in flight without an ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

    // Next-state: grant and capture data in IDLE, then step through LOAD and ACK.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    id_d    = pick_id;
                    data_d  = slice[pick_id];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = ACK;
            end
            ACK: begin
`ifdef LOAD_ARB_LOCK_EN
                if (!lock[id_q]) begin
                    ptr_d = ptr_adv;
                end
`else
                ptr_d = ptr_adv;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode purely from registered state so reset clears them at once.
    always_comb begin
        load = 1'b0;
        d    = '0;
        gnt  = '0;
        ack  = '0;
        busy = (state_q != IDLE);
        case (state_q)
            LOAD: begin
                load       = 1'b1;
                d          = data_q;
                gnt[id_q]  = 1'b1;
            end
            ACK: begin
                gnt[id_q]  = 1'b1;
                ack[id_q]  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_load_arbiter.sv
// Self-checking bench for load_arbiter (N=4, W=4). A transaction-level
// model tracks the cycle of each grant and the round-robin pointer; every
// cycle the DUT outputs are compared with what that grant timeline implies.
// Compile with +define+LOAD_ARB_LOCK_EN to check the lock build.
module tb_load_arbiter;

    localparam int N = 4;
    localparam int W = 4;
`ifdef LOAD_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   lock;
    logic           load;
    logic [W-1:0]   d;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           busy;

    load_arbiter #(.N(N), .W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .data (data),
        .lock (lock),
        .load (load),
        .d    (d),
        .gnt  (gnt),
        .ack  (ack),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: edge number of the last grant, the served id and its data.
    int         cyc;
    int         m_ptr;
    int         m_g;
    int         m_id;
    logic [3:0] m_data;
    logic [3:0] exp_ack;
    bit         auto_rel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_g   = -100;
        m_id  = 0;
    endtask

    // One clock: advance the model at the edge, then compare just after it.
    task automatic cycle();
        int         ph;
        logic       e_load;
        logic [3:0] e_d, e_gnt;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            model_reset();
        end else begin
            if (cyc == m_g + 2) begin
                if (!(LOCK_EN && lock[m_id])) m_ptr = (m_id + 1) % N;
            end
            if (cyc >= m_g + 3 && req != 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % N]) m_id = (m_ptr + k) % N;
                end
                m_data = data[m_id*W +: W];
                m_g    = cyc;
            end
        end
        #1;
        ph      = cyc - m_g;
        e_load  = (ph == 0);
        e_d     = (ph == 0) ? m_data : 4'd0;
        e_gnt   = (ph == 0 || ph == 1) ? 4'(1 << m_id) : 4'd0;
        exp_ack = (ph == 1) ? 4'(1 << m_id) : 4'd0;
        chk("load", {31'd0, load}, {31'd0, e_load});
        chk("d",    {28'd0, d},    {28'd0, e_d});
        chk("gnt",  {28'd0, gnt},  {28'd0, e_gnt});
        chk("ack",  {28'd0, ack},  {28'd0, exp_ack});
        chk("busy", {31'd0, busy}, {31'd0, (ph == 0 || ph == 1)});
        $display("cyc=%0d req=%b load=%b d=%b gnt=%b ack=%b busy=%b",
                 cyc, req, load, d, gnt, ack, busy);
        if (auto_rel) req = req & ~exp_ack;
    endtask

    // Watchdog: the sequence below is bounded, this only guards against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         ld_cyc[$];
        logic [3:0] ld_gnt[$];
        logic [3:0] ld_d[$];
        cyc      = 0;
        auto_rel = 1'b1;
        rst      = 1'b0;
        req      = '0;
        data     = '0;
        lock     = '0;
        model_reset();

        // Reset state.
        cycle();
        cycle();
        rst = 1'b1;
        cycle();

        // Contention: all four requesting continuously from pointer 0.
        auto_rel = 1'b0;
        data     = {4'b1010, 4'b0011, 4'b0101, 4'b1100};
        req      = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (load === 1'b1) begin
                ld_cyc.push_back(cyc);
                ld_gnt.push_back(gnt);
                ld_d.push_back(d);
            end
        end
        req      = '0;
        auto_rel = 1'b1;
        chk("cont_nloads", ld_cyc.size(), 4);
        for (int i = 0; i < ld_cyc.size() && i < 4; i++) begin
            logic [15:0] dv;
            dv = {4'b1010, 4'b0011, 4'b0101, 4'b1100};
            chk($sformatf("cont_gnt%0d", i), {28'd0, ld_gnt[i]}, 32'(1 << i));
            chk($sformatf("cont_d%0d", i), {28'd0, ld_d[i]}, {28'd0, dv[i*4 +: 4]});
            if (i > 0) chk($sformatf("cont_gap%0d", i), ld_cyc[i] - ld_cyc[i-1], 3);
        end
        cycle();
        cycle();

        // Single request from requester 0.
        data = {12'h000, 4'b0110};
        req  = 4'b0001;
        cycle();
        chk("single_d", {28'd0, d}, 32'b0110);
        cycle();
        chk("single_ack", {28'd0, ack}, 32'b0001);
        cycle();
        cycle();

        // Withdrawal: requester 1 drops its request during LOAD.
        data = {8'h00, 4'b1001, 4'h0};
        req  = 4'b0010;
        cycle();
        req  = 4'b0000;
        cycle();
        chk("wd_ack", {28'd0, ack}, 32'b0010);
        cycle();
        cycle();
        chk("wd_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of LOAD.
        req = 4'b0001;
        cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_load", {31'd0, load}, 32'd0);
        chk("arst_gnt",  {28'd0, gnt},  32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ack",  {28'd0, ack},  32'd0);
        req = '0;
        cycle();
        cycle();
        rst  = 1'b1;
        data = {4'h0, 4'b0111, 8'h00};
        req  = 4'b0100;
        cycle();
        chk("post_rst_gnt", {28'd0, gnt}, 32'b0100);
        cycle();
        cycle();

        // Lock held by requester 0 while 0 and 1 both request.
        ld_gnt.delete();
        auto_rel = 1'b0;
        data     = 16'h0021;
        req      = 4'b0011;
        lock     = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (load === 1'b1) ld_gnt.push_back(gnt);
        end
        chk("lock_nloads", ld_gnt.size(), 4);
        for (int i = 0; i < ld_gnt.size(); i++) begin
            logic [3:0] eg;
            eg = (LOCK_EN || (i % 2 == 0)) ? 4'b0001 : 4'b0010;
            chk($sformatf("lock_gnt%0d", i), {28'd0, ld_gnt[i]}, {28'd0, eg});
        end
        lock = '0;
        for (int i = 0; i < 6; i++) cycle();
        req      = '0;
        auto_rel = 1'b1;
        cycle();
        cycle();
        cycle();

        // Randomized traffic with changing data, lock and occasional withdrawal.
        for (int i = 0; i < 300; i++) begin
            data = $urandom;
            lock = 4'($urandom);
            for (int r = 0; r < N; r++) begin
                if (!req[r] && $urandom_range(3) == 0) req[r] = 1'b1;
                else if (req[r] && $urandom_range(15) == 0) req[r] = 1'b0;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
